booth_datapath: RTL

- Datapath for the radix-2 Booth signed multiplier. It sits directly downstream of the multiplier control FSM and executes that FSM's one-hot-per-state control strobes.
- Holds multiplicand M, accumulator A, multiplier Q, guard bit Q[-1] and the iteration counter.
- Returns Q0/Q1/Count status to the FSM.
- Captures and presents the final 2N-bit two's-complement product.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_datapath_if.sv | 35 +++
 rtl/booth_addsub.sv | 23 ++
 rtl/booth_datapath.sv | 95 +++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: default width,
// add/subtract encoding and the control FSM state names.
package booth_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic {
    BOOTH_ADD = 1'b0,
    BOOTH_SUB = 1'b1
  } addsub_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } booth_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage : booth_pkg

// File: rtl/booth_datapath_if.sv
// Control strobes, operands and status/result signals between the Booth
// control FSM (master) and the datapath (slave).
interface booth_datapath_if #(
  parameter int N = booth_pkg::N_DEFAULT
);

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           LoadA;
  logic           LoadB;
  logic           rs;
  logic           cn;
  logic           LoadAdd;
  logic           AddSub;
  logic           Shift;
  logic           c1;
  logic           DONE;

  logic           Q1;
  logic           Q0;
  logic           Count;
  logic [2*N-1:0] product;
  logic           product_valid;

  modport master (
    output mcand, mplier, LoadA, LoadB, rs, cn, LoadAdd, AddSub, Shift, c1, DONE,
    input  Q1, Q0, Count, product, product_valid
  );

  modport slave (
    input  mcand, mplier, LoadA, LoadB, rs, cn, LoadAdd, AddSub, Shift, c1, DONE,
    output Q1, Q0, Count, product, product_valid
  );

endinterface : booth_datapath_if

// File: rtl/booth_addsub.sv
// (N+1)-bit adder/subtractor: sum = a +/- sext(m), modulo 2^(N+1).
module booth_addsub
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] m,
  input  logic         add_sub,
  output logic [N:0]   sum
);

  logic         sub_op;
  logic [N:0]   m_ext;
  logic [N:0]   operand;

  assign sub_op  = (add_sub == BOOTH_SUB);
  assign m_ext   = {m[N-1], m};
  // Subtraction as a + ~m + 1, with the +1 entering as the carry-in term.
  assign operand = sub_op ? ~m_ext : m_ext;
  assign sum     = a + operand + {{N{1'b0}}, sub_op};

endmodule : booth_addsub

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: holds M, A (N+1 bits), Q, Q[-1] and the
// iteration counter, executes the FSM strobes and captures the 2N-bit product.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  booth_datapath_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [N-1:0]   m_q, m_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           product_valid_q, product_valid_d;
  logic [N:0]     addsub_sum;

  booth_addsub #(.N(N)) u_addsub (
    .a       (a_q),
    .m       (m_q),
    .add_sub (bus.AddSub),
    .sum     (addsub_sum)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // block leaves it unassigned and no latch is inferred.
    m_d             = m_q;
    a_d             = a_q;
    q_d             = q_q;
    qm1_d           = qm1_q;
    cnt_d           = cnt_q;
    product_d       = product_q;
    product_valid_d = bus.DONE;

    if (bus.LoadB) m_d = bus.mcand;

    // A and Q[-1]: clear wins over add/sub, which wins over shift.
    if (bus.rs) begin
      a_d   = '0;
      qm1_d = 1'b0;
    end else if (bus.LoadAdd) begin
      a_d   = addsub_sum;
    end else if (bus.Shift) begin
      a_d   = {a_q[N], a_q[N:1]};
      qm1_d = q_q[0];
    end

    if (bus.LoadA)      q_d = bus.mplier;
    else if (bus.Shift) q_d = {a_q[0], q_q[N-1:1]};

    // Counter saturates rather than wrapping.
    if (bus.cn)                         cnt_d = '0;
    else if (bus.c1 && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);

    if (bus.DONE) product_d = {a_q[N-1:0], q_q};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q             <= '0;
      a_q             <= '0;
      q_q             <= '0;
      qm1_q           <= 1'b0;
      cnt_q           <= '0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
    end else begin
      m_q             <= m_d;
      a_q             <= a_d;
      q_q             <= q_d;
      qm1_q           <= qm1_d;
      cnt_q           <= cnt_d;
      product_q       <= product_d;
      product_valid_q <= product_valid_d;
    end
  end

  assign bus.Q1            = q_q[0];
  assign bus.Q0            = qm1_q;
  assign bus.Count         = (cnt_q == CNT_LAST);
  assign bus.product       = product_q;
  assign bus.product_valid = product_valid_q;

endmodule : booth_datapath
